// File: rtl/pad_stream_pkg.sv
// pad_stream_pkg: width-ratio helpers shared by the pad stream bridge and its splitter.
package pad_stream_pkg;

    function automatic int ratio(input int wide, input int narrow);
        return wide / narrow;
    endfunction

    function automatic bit divides(input int wide, input int narrow);
        return narrow > 0 && wide >= narrow && wide % narrow == 0;
    endfunction

    function automatic int idx_w(input int r);
        return r > 1 ? $clog2(r) : 1;
    endfunction

endpackage

// File: rtl/pad_stream_bridge_if.sv
// pad_stream_bridge_if: valid/ready/last/data stream bundle used on every bridge port.
interface pad_stream_bridge_if #(
    parameter int W = 8
);
    logic         valid;
    logic         ready;
    logic         last;
    logic [W-1:0] data;

    modport master(output valid, data, last, input ready);
    modport slave(input valid, data, last, output ready);
endinterface

// File: rtl/stream_splitter.sv
// stream_splitter: two-entry ping-pong word FIFO that emits each word as LSB-first narrow beats.
module stream_splitter
    import pad_stream_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    pad_stream_bridge_if.slave        in_s,
    pad_stream_bridge_if.master       out_m
);
    localparam int ROUT = ratio(IN_W, OUT_W);
    localparam int OW = idx_w(ROUT);
    localparam logic [OW-1:0] LAST_OB = OW'(ROUT - 1);

    logic [IN_W-1:0] mem_q [2];
    logic [IN_W-1:0] mem_d [2];
    logic [1:0]      mlast_q, mlast_d, cnt_q, cnt_d;
    logic [OW-1:0]   ob_q, ob_d;
    logic            wp_q, wp_d, rp_q, rp_d, rdy_q, rdy_d;
    logic            push, fire, pop;

    assign in_s.ready  = rdy_q;
    assign out_m.valid = cnt_q != 2'd0;
    assign out_m.data  = mem_q[rp_q][ob_q*OUT_W +: OUT_W];
    assign out_m.last  = out_m.valid && mlast_q[rp_q] && ob_q == LAST_OB;

    always_comb begin
        push    = in_s.valid && rdy_q;
        fire    = out_m.valid && out_m.ready;
        pop     = fire && ob_q == LAST_OB;
        mem_d   = mem_q;
        mlast_d = mlast_q;
        if (push) begin
            mem_d[wp_q]   = in_s.data;
            mlast_d[wp_q] = in_s.last;
        end
        wp_d  = wp_q ^ push;
        rp_d  = rp_q ^ pop;
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
        ob_d  = fire ? (pop ? '0 : ob_q + 1'b1) : ob_q;
        rdy_d = cnt_d < 2'd2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            mlast_q <= '0;
            cnt_q   <= '0;
            ob_q    <= '0;
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            mem_q   <= mem_d;
            mlast_q <= mlast_d;
            cnt_q   <= cnt_d;
            ob_q    <= ob_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            rdy_q   <= rdy_d;
        end
    end
endmodule

// File: rtl/pad_stream_bridge.sv
// pad_stream_bridge: packs narrow pad beats into core words and splits core results into pad beats.
// Define PAD_BITREV_EN to bit-reverse each incoming pad beat before packing.
module pad_stream_bridge
    import pad_stream_pkg::*;
#(
    parameter int PAD_IN_W   = 8,
    parameter int CORE_IN_W  = 16,
    parameter int CORE_OUT_W = 32,
    parameter int PAD_OUT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    pad_stream_bridge_if.slave   pad_in,
    pad_stream_bridge_if.master  core_in,
    pad_stream_bridge_if.slave   core_out,
    pad_stream_bridge_if.master  pad_out
);
    localparam int RIN = ratio(CORE_IN_W, PAD_IN_W);
    localparam int IW = idx_w(RIN);
    localparam logic [IW-1:0] LAST_IDX = IW'(RIN - 1);

    if (!divides(CORE_IN_W, PAD_IN_W) || !divides(CORE_OUT_W, PAD_OUT_W)) begin : g_bad_ratio
        $error("pad_stream_bridge: core widths must be integer multiples of pad widths");
    end

    logic [CORE_IN_W-1:0] acc_q, acc_d, acc_w, iw_q, iw_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 iw_full_q, iw_full_d, iw_last_q, iw_last_d;
    logic                 pend_q, pend_d, pend_last_q, pend_last_d;
    logic [PAD_IN_W-1:0]  beat;
    logic                 take, done;

`ifdef PAD_BITREV_EN
    always_comb for (int i = 0; i < PAD_IN_W; i++) beat[i] = pad_in.data[PAD_IN_W-1-i];
`else
    assign beat = pad_in.data;
`endif

    // A pending word lives in acc until iw frees, so no beats may enter meanwhile.
    assign pad_in.ready  = !pend_q && !(iw_full_q && idx_q == LAST_IDX);
    assign core_in.valid = iw_full_q;
    assign core_in.data  = iw_q;
    assign core_in.last  = iw_last_q;

    always_comb begin
        take  = pad_in.valid && pad_in.ready;
        done  = take && (idx_q == LAST_IDX || pad_in.last);
        acc_w = idx_q == '0 ? '0 : acc_q;
        acc_w[idx_q*PAD_IN_W +: PAD_IN_W] = beat;
        acc_d       = take ? acc_w : acc_q;
        idx_d       = take ? (done ? '0 : idx_q + 1'b1) : idx_q;
        iw_d        = iw_q;
        iw_last_d   = iw_last_q;
        iw_full_d   = iw_full_q && !core_in.ready;
        pend_d      = pend_q;
        pend_last_d = pend_last_q;
        if (pend_q && core_in.ready) begin
            iw_d      = acc_q;
            iw_last_d = pend_last_q;
            iw_full_d = 1'b1;
            pend_d    = 1'b0;
        end else if (done && !iw_full_d) begin
            iw_d      = acc_w;
            iw_last_d = pad_in.last;
            iw_full_d = 1'b1;
        end else if (done) begin
            pend_d      = 1'b1;
            pend_last_d = pad_in.last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            idx_q       <= '0;
            iw_q        <= '0;
            iw_last_q   <= 1'b0;
            iw_full_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            iw_q        <= iw_d;
            iw_last_q   <= iw_last_d;
            iw_full_q   <= iw_full_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
        end
    end

    stream_splitter #(
        .IN_W (CORE_OUT_W),
        .OUT_W(PAD_OUT_W)
    ) u_split (
        .clk  (clk),
        .rst  (rst),
        .in_s (core_out),
        .out_m(pad_out)
    );
endmodule

// File: tb/tb_pad_stream_bridge.sv
// tb_pad_stream_bridge: directed stimulus with a queue-based stream model and literal word checks.
module tb_pad_stream_bridge;
    localparam int PIW = 8, CIW = 16, COW = 32, POW = 16;

`ifdef PAD_BITREV_EN
    localparam logic [15:0] T1_W0 = 16'h8520, T1_W1 = 16'h43EC, T2_W0 = 16'h4488, T2_W1 = 16'h00CC;
    localparam logic [15:0] T5_W0 = 16'h4A8A, T5_W1 = 16'h00CA, T5_W2 = 16'hAA2A, T6_W0 = 16'h4080;
`else
    localparam logic [15:0] T1_W0 = 16'hA104, T1_W1 = 16'hC237, T2_W0 = 16'h2211, T2_W1 = 16'h0033;
    localparam logic [15:0] T5_W0 = 16'h5251, T5_W1 = 16'h0053, T5_W2 = 16'h5554, T6_W0 = 16'h0201;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pad_stream_bridge_if #(.W(PIW)) pin ();
    pad_stream_bridge_if #(.W(CIW)) cin ();
    pad_stream_bridge_if #(.W(COW)) cout ();
    pad_stream_bridge_if #(.W(POW)) pout ();

    pad_stream_bridge #(
        .PAD_IN_W(PIW), .CORE_IN_W(CIW), .CORE_OUT_W(COW), .PAD_OUT_W(POW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pad_in  (pin),
        .core_in (cin),
        .core_out(cout),
        .pad_out (pout)
    );

    int total = 0, bad = 0;
    int drops = 0, pin_cnt = 0, cout_cnt = 0, n = 0;
    logic [15:0] cur = '0;
    logic [16:0] exp_ci[$], exp_po[$], cin_log[$], pout_log[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_beat(input logic [7:0] b);
        logic [7:0] r;
        r = b;
`ifdef PAD_BITREV_EN
        for (int k = 0; k < 8; k++) r[k] = b[7-k];
`endif
        return r;
    endfunction

    // Model: rebuild words/beats from observed accepted transfers, then hold the DUT to them.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            cur = '0;
            n = 0;
            exp_ci.delete();
            exp_po.delete();
        end else begin
            if (cin.valid) begin
                check("core_in_word", {cin.last, cin.data}, exp_ci.size() != 0 ? exp_ci[0] : 17'bx);
                if (cin.ready) begin
                    cin_log.push_back({cin.last, cin.data});
                    if (exp_ci.size() != 0) void'(exp_ci.pop_front());
                end
            end
            if (pin.valid && pin.ready) begin
                cur = cur | (CIW'(model_beat(pin.data)) << (PIW * n));
                n++;
                pin_cnt++;
                if (n == CIW / PIW || pin.last) begin
                    exp_ci.push_back({pin.last, cur});
                    cur = '0;
                    n = 0;
                end
            end else if (pin.valid) drops++;
            if (pout.valid) begin
                check("pad_out_beat", {pout.last, pout.data}, exp_po.size() != 0 ? exp_po[0] : 17'bx);
                if (pout.ready) begin
                    pout_log.push_back({pout.last, pout.data});
                    if (exp_po.size() != 0) void'(exp_po.pop_front());
                end
            end
            if (cout.valid && cout.ready) begin
                for (int k = 0; k < COW / POW; k++)
                    exp_po.push_back({cout.last && k == COW / POW - 1, cout.data[k*POW +: POW]});
                cout_cnt++;
            end
        end
    end

    task automatic cyc(input int c);
        repeat (c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_pad(input logic [7:0] d, input logic l);
        int t = 0;
        pin.valid = 1'b1;
        pin.data  = d;
        pin.last  = l;
        @(negedge clk);
        while (!pin.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("pad_in_ready_wait", pin.ready, 1);
        @(posedge clk);
        #1;
        pin.valid = 1'b0;
        pin.last  = 1'b0;
    endtask

    task automatic send_core(input logic [31:0] d, input logic l);
        int t = 0;
        cout.valid = 1'b1;
        cout.data  = d;
        cout.last  = l;
        @(negedge clk);
        while (!cout.ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("core_out_ready_wait", cout.ready, 1);
        @(posedge clk);
        #1;
        cout.valid = 1'b0;
        cout.last  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_ci.size() != 0 || exp_po.size() != 0) && t < 100) begin
            cyc(1);
            t++;
        end
        cyc(2);
        check("drain_core_in", exp_ci.size(), 0);
        check("drain_pad_out", exp_po.size(), 0);
    endtask

    function automatic logic [16:0] at(input logic [16:0] q[$], input int i);
        return i < q.size() ? q[i] : 17'bx;
    endfunction

    logic [16:0] bp_exp [6] = '{17'h02222, 17'h01111, 17'h04444, 17'h03333, 17'h06666, 17'h15555};

    initial begin
        pin.valid = 0; pin.data = '0; pin.last = 0; cin.ready = 1;
        cout.valid = 0; cout.data = '0; cout.last = 0; pout.ready = 1;
        cyc(2);
        check("rst_pad_in_ready", pin.ready, 1);
        check("rst_core_out_ready", cout.ready, 1);
        check("rst_core_in_valid", cin.valid, 0);
        check("rst_core_in_last", cin.last, 0);
        check("rst_core_in_data", cin.data, 0);
        check("rst_pad_out_valid", pout.valid, 0);
        check("rst_pad_out_last", pout.last, 0);
        check("rst_pad_out_data", pout.data, 0);
        rst = 1'b0;
        cyc(1);

        drops = 0; cin_log.delete();
        send_pad(8'h04, 0);
        check("t1_no_word_yet", cin.valid, 0);
        send_pad(8'hA1, 0);
        check("t1_latency_valid", cin.valid, 1);
        check("t1_latency_data", cin.data, T1_W0);
        send_pad(8'h37, 0);
        send_pad(8'hC2, 1);
        drain();
        check("t1_ready_drops", drops, 0);
        check("t1_count", cin_log.size(), 2);
        check("t1_w0", at(cin_log, 0), {1'b0, T1_W0});
        check("t1_w1", at(cin_log, 1), {1'b1, T1_W1});

        cin_log.delete();
        send_pad(8'h11, 0);
        send_pad(8'h22, 0);
        send_pad(8'h33, 1);
        drain();
        check("t2_count", cin_log.size(), 2);
        check("t2_w0", at(cin_log, 0), {1'b0, T2_W0});
        check("t2_w1", at(cin_log, 1), {1'b1, T2_W1});

        pout_log.delete();
        send_core(32'hDEADBEEF, 1);
        check("t3_latency_valid", pout.valid, 1);
        check("t3_first_beat", {pout.last, pout.data}, 17'h0BEEF);
        cyc(1);
        check("t3_second_beat", {pout.last, pout.data}, 17'h1DEAD);
        drain();
        check("t3_count", pout_log.size(), 2);

        pout_log.delete(); cout_cnt = 0; pout.ready = 0;
        fork
            begin
                send_core(32'h11112222, 0);
                send_core(32'h33334444, 0);
                send_core(32'h55556666, 1);
            end
            begin
                cyc(10);
                check("t4_accepted", cout_cnt, 2);
                check("t4_core_out_ready", cout.ready, 0);
                check("t4_held_beat", {pout.valid, pout.data}, 17'h12222);
                pout.ready = 1;
            end
        join
        drain();
        check("t4_count", pout_log.size(), 6);
        for (int i = 0; i < 6; i++) check("t4_beat", at(pout_log, i), bp_exp[i]);

        cin_log.delete(); pin_cnt = 0; cin.ready = 0;
        fork
            begin
                send_pad(8'h51, 0);
                send_pad(8'h52, 0);
                send_pad(8'h53, 1);
                send_pad(8'h54, 0);
                send_pad(8'h55, 0);
            end
            begin
                cyc(8);
                check("t5_accepted", pin_cnt, 3);
                check("t5_pad_in_ready", pin.ready, 0);
                check("t5_held_word", {cin.valid, cin.data}, {1'b1, T5_W0});
                cin.ready = 1;
            end
        join
        drain();
        check("t5_count", cin_log.size(), 3);
        check("t5_w0", at(cin_log, 0), {1'b0, T5_W0});
        check("t5_w1", at(cin_log, 1), {1'b1, T5_W1});
        check("t5_w2", at(cin_log, 2), {1'b0, T5_W2});

        send_pad(8'h77, 0);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cin_log.delete();
        for (int i = 0; i < 4; i++) begin
            check("t6_quiet_core_in", cin.valid, 0);
            check("t6_quiet_pad_out", pout.valid, 0);
            cyc(1);
        end
        send_pad(8'h01, 0);
        send_pad(8'h02, 1);
        drain();
        check("t6_count", cin_log.size(), 1);
        check("t6_w0", at(cin_log, 0), {1'b1, T6_W0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end
endmodule
